// File: rtl/id_ex_pipe.sv
// ID/EX pipeline stage: valid/ready handshake, 2-entry skid buffer, flush-to-bubble,
// forwarding-address extraction on load and a saturating back-pressure counter.
module id_ex_pipe #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] read1,
  input  logic [DATA_W-1:0] read2,
  input  logic [DATA_W-1:0] sign_extended,
  input  logic [31:0]       instruction,
  input  logic [1:0]        aluOp,
  input  logic              aluSrc,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              regWrite,
  input  logic              memtoReg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Pc,
  output logic [DATA_W-1:0] Read1,
  output logic [DATA_W-1:0] Read2,
  output logic [DATA_W-1:0] Sign_extended,
  output logic [10:0]       alu_ctrl_data,
  output logic [4:0]        write_reg,
  output logic [4:0]        rn_addr,
  output logic [4:0]        rm_addr,
  output logic [1:0]        AluOp,
  output logic              ALUSrc,
  output logic              Branch,
  output logic              Uncond_Branch,
  output logic              Memread,
  output logic              Memwrite,
  output logic              RegWrite,
  output logic              MemtoReg,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned CTRL_W = 9;
  localparam int unsigned FLD_W  = 26;
  localparam int unsigned DAT_W  = 4 * DATA_W;
  localparam int unsigned BUN_W  = CTRL_W + FLD_W + DAT_W;

  // bit0 = main valid, bit1 = skid valid
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_in_ready;
  logic [BUN_W-1:0] r_main;
  logic [BUN_W-1:0] r_skid;
  logic [BUN_W-1:0] w_main_nxt;
  logic [BUN_W-1:0] w_skid_nxt;
  logic [BUN_W-1:0] w_in_bun;
  logic [CNT_W-1:0] r_stall;
  logic             w_main_valid;
  logic             w_acc;
  logic             w_pop;
  logic             w_unused_bits;

  // Fields are extracted once here, at load time
  assign w_in_bun = {aluOp, aluSrc, branch, uncond_branch, memread, memwrite, regWrite,
                     memtoReg, instruction[31:21], instruction[20:16], instruction[9:5],
                     instruction[4:0], pc, read1, read2, sign_extended};
  assign w_unused_bits = ^instruction[15:10];

  assign w_main_valid = r_state[0];
  assign w_acc        = in_valid & r_in_ready & ~flush;
  assign w_pop        = w_main_valid & out_ready;

  // Next occupancy and storage; main control bits are zeroed whenever main goes invalid
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt                       = ST_EMPTY;
      w_main_nxt[BUN_W-1 -: CTRL_W]     = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = w_in_bun;
          end
        end
        ST_ONE: begin
          if (w_acc && !w_pop) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = w_in_bun;
          end else if (w_acc && w_pop) begin
            w_main_nxt  = w_in_bun;
          end else if (w_pop) begin
            w_state_nxt                   = ST_EMPTY;
            w_main_nxt[BUN_W-1 -: CTRL_W] = '0;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
      r_stall    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      if (w_main_valid && !out_ready && !flush && (r_stall != CNT_MAX))
        r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign {AluOp, ALUSrc, Branch, Uncond_Branch, Memread, Memwrite, RegWrite, MemtoReg,
          alu_ctrl_data, rm_addr, rn_addr, write_reg,
          Pc, Read1, Read2, Sign_extended} = r_main;
  assign out_valid    = w_main_valid;
  assign in_ready     = r_in_ready;
  assign stall_cycles = r_stall;

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Parametrised ID/EX pipeline stage. Successor to the plain ID/EX register.
- Adds a valid/ready handshake, a 2-entry skid buffer, a flush that inserts a bubble, and forwarding-address extraction.
- Sits between the decode/register-read logic and the execute stage of the pipelined LEGv8 CPU.
- Includes a saturating back-pressure stall counter for performance debug.

Parameters:
DATA_W, 64, width of pc, read1, read2, sign_extended and their registered copies
CNT_W, 16, width of the stall_cycles counter

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode has a valid instruction bundle
in_ready  out  1  stage can accept a bundle this cycle
flush  in  1  discard all held bundles (branch taken / squash)
pc, read1, read2, sign_extended  in  DATA_W each  decode data
instruction  in  32  fetched instruction
aluOp  in  2; aluSrc, branch, uncond_branch, memread, memwrite, regWrite, memtoReg  in  1 each  decode control
out_valid  out  1  execute-side bundle valid
out_ready  in  1  execute accepts the bundle this cycle
Pc, Read1, Read2, Sign_extended  out  DATA_W each  registered data
alu_ctrl_data  out  11  instruction[31:21]
write_reg  out  5  instruction[4:0]
rn_addr  out  5  instruction[9:5], for forwarding
rm_addr  out  5  instruction[20:16], for forwarding
AluOp  out  2; ALUSrc, Branch, Uncond_Branch, Memread, Memwrite, RegWrite, MemtoReg  out  1 each  registered control
stall_cycles  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Storage: a main register (drives the outputs) and a skid register, each holding the full bundle plus a valid bit.
- Occupancy states:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- in_ready = !skid_valid. It is a registered state bit; it has no combinational path from out_ready.
- Handshakes:
  - acc = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready.
  - out_valid = main_valid.
- Transitions (flush = 0):
  - EMPTY: acc -> ONE, bundle loaded into main.
  - ONE: acc & !pop -> FULL, bundle into skid. acc & pop -> ONE, main reloaded with the new bundle. !acc & pop -> EMPTY. Otherwise hold.
  - FULL: acc is impossible because in_ready = 0. pop -> ONE, skid moves to main. Otherwise hold.
- Latency: one cycle from acceptance to out_valid when the stage is EMPTY or being popped. Throughput is one bundle per cycle with out_ready held high.
- Ordering is strictly FIFO. No bundle is dropped or duplicated except by flush.
- flush:
  - Next state is EMPTY. Any bundle presented in the same cycle is discarded.
  - Both valid bits clear, and all control outputs (AluOp, ALUSrc, Branch, Uncond_Branch, Memread, Memwrite, RegWrite, MemtoReg) are zero from the next cycle.
  - Data outputs may hold stale values.
  - A pop coinciding with a flush still counts as consumed by execute.
- Bubble rule: whenever out_valid = 0, all control outputs are 0. Execute needs no extra gating.
- Reset:
  - Applies at the edge where reset = 1 and takes priority over flush and handshakes.
  - All outputs become 0, including Pc, data, address fields, out_valid and stall_cycles.
  - in_ready = 1 after the reset edge.
  - Reset mid-FULL discards both bundles.
- stall_cycles:
  - Increments on every edge where out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared only by reset.
- Field extraction happens on load (into main or skid). It is not recomputed from a live instruction.

Test Plan:
- Reset, then stream 4 bundles with pc = 0x100, 0x104, 0x108, 0x10C and out_ready = 1 -> out_valid rises 1 cycle after the first accept; Pc sequence is 0x100..0x10C on consecutive cycles; in_ready stays 1.
- Load instruction 0x8B020020 (ADD X0,X1,X2) -> alu_ctrl_data = 0x458, rn_addr = 1, rm_addr = 2, write_reg = 0.
- out_ready = 0 while 3 bundles are offered -> first two held (FULL); in_ready = 0 after the 2nd; 3rd not accepted until out_ready = 1; output order is preserved; stall_cycles counts each blocked cycle.
- In FULL state with RegWrite = 1 and Memwrite = 1 bundles, assert flush for 1 cycle with in_valid = 1 -> next cycle out_valid = 0, all control outputs 0, in_ready = 1; the flushed-cycle input never appears.
- CNT_W = 4, out_ready held 0 for 20 cycles -> stall_cycles = 15 and stays at 15.
- Assert reset for 1 cycle while FULL with stall_cycles = 7 -> all outputs 0, in_ready = 1, stall_cycles = 0; the next accepted bundle appears normally.
